mips_boot_loader: RTL and testbench

//  Upstream stage of the mips/exmem pair. Accepts a byte stream (e.g. from a UART

---
 rtl/mips_boot_loader.sv | 199 +++++++++++++++++++
 tb/tb_mips_boot_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_boot_loader
// Description : Byte-stream boot loader placed between the mips core and
//               exmem. Receives a length byte, that many image bytes and a
//               checksum byte. Image bytes are written straight into exmem
//               starting at ADDR_BASE while the CPU is held in reset. A good
//               checksum hands the memory bus to the CPU and releases its
//               reset; a bad one parks the loader in an error state until a
//               SYNC byte restarts the download.
// Ports       : clk            - system clock, rising edge
//               reset          - synchronous, active-low
//               rx_data/valid  - incoming byte stream
//               rx_ready       - loader accepts rx_data this cycle
//               cpu_*          - memory bus from mips (used only in RUN)
//               mem_*          - memory bus to exmem
//               cpu_rst        - active-high reset to mips
//               boot_done      - image loaded, checksum good, CPU running
//               boot_err       - checksum mismatch, CPU held in reset
// Revision    : 1.0 - initial release
// ============================================================================
module mips_boot_loader #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ADDR_BASE = '0,
    parameter logic [WIDTH-1:0] SYNC      = 'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_writedata,
    output logic             cpu_rst,
    output logic             boot_done,
    output logic             boot_err
);

    typedef enum logic [2:0] {
        S_WAIT_LEN = 3'd0,
        S_LOAD     = 3'd1,
        S_CHECK    = 3'd2,
        S_RUN      = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_len;
    logic [WIDTH:0]   r_cnt;       // one extra bit so a full 2^WIDTH image can be counted
    logic [WIDTH-1:0] r_sum;
    logic             r_cpu_rst;
    logic             r_boot_done;
    logic             r_boot_err;

    logic [WIDTH:0]   w_cnt_inc;
    logic [WIDTH:0]   w_len_ext;
    logic             w_last;
    logic [WIDTH-1:0] w_load_adr;

    logic             w_rx_ready;
    logic             w_mem_memread;
    logic             w_mem_memwrite;
    logic [WIDTH-1:0] w_mem_adr;
    logic [WIDTH-1:0] w_mem_writedata;

    // A length byte of zero stands for a full 2^WIDTH-byte image.
    assign w_len_ext  = (r_len == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, r_len};
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = (w_cnt_inc == w_len_ext);
    // Address arithmetic wraps modulo 2^WIDTH by truncation.
    assign w_load_adr = ADDR_BASE + r_cnt[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_WAIT_LEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and bus outputs. rx_ready is high in every state but RUN, so
    // outside RUN a transfer is simply rx_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_rx_ready      = 1'b1;
        w_mem_memread   = 1'b0;
        w_mem_memwrite  = 1'b0;
        w_mem_adr       = w_load_adr;
        w_mem_writedata = rx_data;

        case (r_state)
            S_WAIT_LEN: begin
                if (rx_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // exmem captures on the same edge as the transfer.
                w_mem_memwrite = rx_valid;
                if (rx_valid && w_last) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = (rx_data == r_sum) ? S_RUN : S_ERROR;
                end
            end
            S_RUN: begin
                // Pure pass-through of the CPU bus; no added latency.
                w_rx_ready      = 1'b0;
                w_mem_memread   = cpu_memread;
                w_mem_memwrite  = cpu_memwrite;
                w_mem_adr       = cpu_adr;
                w_mem_writedata = cpu_writedata;
            end
            S_ERROR: begin
                if (rx_valid && (rx_data == SYNC)) begin
                    w_state_nxt = S_WAIT_LEN;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LEN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cpu_rst   <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_LEN: begin
                    if (rx_valid) begin
                        r_len <= rx_data;
                        r_cnt <= '0;
                        r_sum <= '0;
                    end
                end
                S_LOAD: begin
                    if (rx_valid) begin
                        r_cnt <= w_cnt_inc;
                        r_sum <= r_sum + rx_data;
                    end
                end
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == r_sum) begin
                            // CPU leaves reset on the edge that enters RUN.
                            r_cpu_rst   <= 1'b0;
                            r_boot_done <= 1'b1;
                        end else begin
                            r_boot_err  <= 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    if (rx_valid && (rx_data == SYNC)) begin
                        r_boot_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready      = w_rx_ready;
    assign mem_memread   = w_mem_memread;
    assign mem_memwrite  = w_mem_memwrite;
    assign mem_adr       = w_mem_adr;
    assign mem_writedata = w_mem_writedata;
    assign cpu_rst       = r_cpu_rst;
    assign boot_done     = r_boot_done;
    assign boot_err      = r_boot_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_boot_loader
// Description : Self-checking bench for mips_boot_loader. Expected exmem
//               writes are queued as image bytes are issued and checked by an
//               independent bus monitor; status outputs are checked against
//               the download rules (address = base + index, checksum = byte
//               sum mod 256).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_boot_loader;

    localparam logic [7:0] c_base = 8'hFD;   // non-zero so long images wrap

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cpu_memread;
    logic       cpu_memwrite;
    logic [7:0] cpu_adr;
    logic [7:0] cpu_writedata;
    logic       mem_memread;
    logic       mem_memwrite;
    logic [7:0] mem_adr;
    logic [7:0] mem_writedata;
    logic       cpu_rst;
    logic       boot_done;
    logic       boot_err;

    mips_boot_loader #(
        .WIDTH     (8),
        .ADDR_BASE (c_base),
        .SYNC      (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .cpu_memread   (cpu_memread),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_adr       (cpu_adr),
        .cpu_writedata (cpu_writedata),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_adr       (mem_adr),
        .mem_writedata (mem_writedata),
        .cpu_rst       (cpu_rst),
        .boot_done     (boot_done),
        .boot_err      (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    bit         mon_off = 1'b1;
    logic [7:0] img[$];
    logic [7:0] exp_adr[$];
    logic [7:0] exp_dat[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference checksum: plain byte sum modulo 256.
    function automatic logic [7:0] img_sum();
        int s = 0;
        foreach (img[i]) s += int'(img[i]);
        return 8'(s % 256);
    endfunction

    // Bus monitor: every exmem write must match the next queued expectation.
    always @(negedge clk) begin
        if (!mon_off && mem_memwrite === 1'b1) begin
            chk("write_was_expected", int'(exp_adr.size() != 0), 1);
            if (exp_adr.size() != 0) begin
                chk("wr_adr", int'(mem_adr), int'(exp_adr.pop_front()));
                chk("wr_data", int'(mem_writedata), int'(exp_dat.pop_front()));
            end
        end
    end

    // All main-process activity starts at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        gap = int'($urandom_range(0, maxgap));
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("rx_ready", int'(rx_ready), 1);
        chk("cpu_rst_held", int'(cpu_rst), 1);
        chk("boot_done_low", int'(boot_done), 0);
        chk("memread_gated", int'(mem_memread), 0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_status(input int done, input int err, input int rst, input int rdy);
        @(negedge clk);
        chk("boot_done", int'(boot_done), done);
        chk("boot_err", int'(boot_err), err);
        chk("cpu_rst", int'(cpu_rst), rst);
        chk("rx_ready_st", int'(rx_ready), rdy);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        mon_off      = 1'b1;
        cpu_memwrite = 1'b0;
        cpu_memread  = 1'b0;
        rx_valid     = 1'b0;
        reset        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("sb_drained", exp_adr.size(), 0);
        exp_adr.delete();
        exp_dat.delete();
        // CPU bus noise must be ignored outside RUN.
        cpu_memwrite  = 1'b1;
        cpu_memread   = 1'b1;
        cpu_adr       = 8'($urandom);
        cpu_writedata = 8'($urandom);
        mon_off       = 1'b0;
        @(negedge clk);
        chk("rst_memwrite", int'(mem_memwrite), 0);
        chk("rst_memread", int'(mem_memread), 0);
        @(posedge clk); #1;
        check_status(0, 0, 1, 1);
    endtask

    // Download img with the given length and checksum bytes.
    task automatic boot(input logic [7:0] lenb, input logic [7:0] csum, input int maxgap);
        bit good;
        good = (csum == img_sum());
        send_byte(lenb, maxgap);
        for (int i = 0; i < img.size(); i++) begin
            exp_adr.push_back(8'((int'(c_base) + i) % 256));
            exp_dat.push_back(img[i]);
            send_byte(img[i], maxgap);
        end
        send_byte(csum, maxgap);
        mon_off = good;
        chk("image_written", exp_adr.size(), 0);
        check_status(int'(good), int'(!good), int'(!good), int'(!good));
    endtask

    task automatic run_mux();
        mon_off = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpu_adr       = 8'($urandom);
            cpu_writedata = 8'($urandom);
            cpu_memwrite  = 1'($urandom);
            cpu_memread   = 1'($urandom);
            @(negedge clk);
            chk("run_adr", int'(mem_adr), int'(cpu_adr));
            chk("run_wdata", int'(mem_writedata), int'(cpu_writedata));
            chk("run_memwrite", int'(mem_memwrite), int'(cpu_memwrite));
            chk("run_memread", int'(mem_memread), int'(cpu_memread));
            chk("run_rx_ready", int'(rx_ready), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] s;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;
        @(posedge clk); #1;

        // Reset state
        do_reset();

        // Basic image
        img = '{8'h11, 8'h22, 8'h33};
        boot(8'h03, 8'h66, 0);
        run_mux();

        // Bad checksum, discarded bytes, SYNC recovery
        do_reset();
        img = '{8'h10, 8'h20};
        boot(8'h02, 8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            s = 8'($urandom);
            if (s == 8'hA5) s = 8'h5A;
            send_byte(s, 1);
            check_status(0, 1, 1, 1);
        end
        send_byte(8'hA5, 0);
        check_status(0, 0, 1, 1);
        img = '{8'h7F};
        boot(8'h01, 8'h7F, 0);
        run_mux();

        // Same basic image with idle gaps
        do_reset();
        img = '{8'h11, 8'h22, 8'h33};
        boot(8'h03, 8'h66, 3);

        // Full 256-byte image, wraps past 0xFF
        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(8'(i));
        boot(8'h00, 8'h80, 0);
        run_mux();

        // Reset mid-download, then a fresh image
        do_reset();
        send_byte(8'h04, 0);
        for (int i = 0; i < 2; i++) begin
            exp_adr.push_back(8'((int'(c_base) + i) % 256));
            exp_dat.push_back(8'hC0 + 8'(i));
            send_byte(8'hC0 + 8'(i), 0);
        end
        do_reset();
        img = '{8'h05, 8'h06, 8'h07};
        boot(8'h03, 8'h12, 1);
        run_mux();

        // Random images, some with corrupted checksum
        for (int t = 0; t < 6; t++) begin
            int n;
            do_reset();
            n = int'($urandom_range(1, 20));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            s = img_sum();
            if ($urandom_range(0, 2) == 0) s = s + 8'($urandom_range(1, 255));
            boot(8'(n), s, 3);
            if (boot_done) run_mux();
            else check_status(0, 1, 1, 1);
        end

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
